rca_pipe: RTL and testbench

RCA_PIPE -- requirements
Module: rca_pipe

---
 rtl/rca_pkg.sv | 12 +
 rtl/rca_chunk.sv | 29 ++
 rtl/rca_pipe.sv | 121 ++++++++++++
 tb/tb_rca_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package rca_pkg;

  localparam int RCA_WIDTH  = 8;
  localparam int RCA_STAGES = 2;

  // Bits added per pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CW-bit ripple-carry adder slice used once per pipeline stage.
module rca_chunk
  import rca_pkg::*;
#(
  parameter int CW = chunk_width(RCA_WIDTH, RCA_STAGES)
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);

  logic [CW:0] c;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[CW];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder, one slice per stage with a global stall.
// Optional macro RCA_PIPE_SUB_EN adds a per-beat 'sub' input (num1 - num2).
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH  = RCA_WIDTH,
  parameter int STAGES = RCA_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
`ifdef RCA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("rca_pipe: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  // Index k is what stage k consumes; index k+1 is what stage k registered.
  logic             v_s   [STAGES+1];
  logic             c_s   [STAGES+1];
  logic [WIDTH-1:0] s_s   [STAGES+1];
  logic [WIDTH-1:0] a_s   [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];
  logic             sub_s [STAGES];

  assign in_ready = !out_valid || out_ready;

  assign v_s[0] = in_valid;
  assign s_s[0] = '0;
  assign a_s[0] = num1;
  assign b_s[0] = num2;
`ifdef RCA_PIPE_SUB_EN
  assign sub_s[0] = sub;
`else
  assign sub_s[0] = 1'b0;
`endif
  // Subtraction is num1 + ~num2 + 1, so the carry-in is forced high.
  assign c_s[0] = sub_s[0] ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             co;
    logic [WIDTH-1:0] s_next;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] s_q;

    assign b_slice = b_s[k][k*CHUNK +: CHUNK] ^ {CHUNK{sub_s[k]}};

    rca_chunk #(.CW(CHUNK)) u_chunk (
      .a  (a_s[k][k*CHUNK +: CHUNK]),
      .b  (b_slice),
      .ci (c_s[k]),
      .s  (s_slice),
      .co (co)
    );

    always_comb begin
      s_next                    = s_s[k];
      s_next[k*CHUNK +: CHUNK]  = s_slice;
    end

    // NOTE: data registers are cleared with the valids so nothing stale is ever visible on sum.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (in_ready) begin
        // NOTE: sequential state uses non-blocking assignment so all stages shift on the same edge.
        v_q <= v_s[k];
        c_q <= co;
        s_q <= s_next;
      end
    end

    assign v_s[k+1] = v_q;
    assign c_s[k+1] = c_q;
    assign s_s[k+1] = s_q;

    // Operands still to be added travel with the beat; the last stage needs none.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             sub_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (in_ready) begin
          a_q   <= a_s[k];
          b_q   <= b_s[k];
          sub_q <= sub_s[k];
        end
      end

      assign a_s[k+1]   = a_q;
      assign b_s[k+1]   = b_q;
      assign sub_s[k+1] = sub_q;
    end
  end

  assign out_valid = v_s[STAGES];
  assign sum       = {c_s[STAGES], s_s[STAGES]};

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe (WIDTH=8, STAGES=2): vector table, corner sequences
// and randomized traffic against a queue-based arithmetic reference model.
module tb_rca_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] num1;
  logic [7:0] num2;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q [$];

  typedef struct {
    logic [7:0] n1;
    logic [7:0] n2;
    logic       ci;
    logic       sb;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [$];

  rca_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .cin       (cin),
`ifdef RCA_PIPE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    int unsigned r;
    if (s) r = int'(a) + (255 - int'(b)) + 1;
    else   r = int'(a) + int'(b) + int'(c);
    return r[8:0];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: decide transfers mid-cycle, when all signals are settled.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
        else check("stream_sum", sum, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(num1, num2, cin, sub));
    end
  end

  task automatic send_one(input vec_t v);
    in_valid = 1'b1; num1 = v.n1; num2 = v.n2; cin = v.ci; sub = v.sb; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("lat1_valid", out_valid, 0);
    cycle();
    check("lat2_valid", out_valid, 1);
    check("vec_sum", sum, v.exp);
    cycle();
    check("lat3_valid", out_valid, 0);
  endtask

  initial begin
    logic [8:0] held;
    int         run;
    int         seen;
    logic       bub_in  [5];
    logic       bub_out [5];

    reset = 1'b1; in_valid = 1'b0; num1 = '0; num2 = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    cycle();

    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 9'h000});
    vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 9'h010});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 9'h100});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 9'h080});
    vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 9'h100});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 9'h046});
`ifdef RCA_PIPE_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 9'h102});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 9'h100});
`endif
    for (int i = 0; i < vecs.size(); i++) send_one(vecs[i]);

    // Streaming: 256 back-to-back beats must emerge as one unbroken run.
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          in_valid = 1'b1; num1 = 8'(i); num2 = 8'h10; cin = 1'b0; sub = 1'b0;
          cycle();
        end
        in_valid = 1'b0;
      end
      begin
        run = 0;
        for (int t = 0; t < 10 && !out_valid; t++) begin
          @(posedge clk); #2;
        end
        while (out_valid && run < 300) begin
          run++;
          @(posedge clk); #2;
        end
        check("stream_run_len", run, 256);
      end
    join
    repeat (3) cycle();
    check("stream_drained", exp_q.size(), 0);

    // Backpressure with both stages full.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      num1 = 8'($urandom); num2 = 8'($urandom); cin = 1'($urandom_range(0, 1));
      cycle();
    end
    num1 = 8'($urandom); num2 = 8'($urandom); cin = 1'($urandom_range(0, 1));
    out_ready = 1'b0;
    #1;
    check("bp_full_valid", out_valid, 1);
    held = sum;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      cycle();
      check("bp_sum_hold", sum, held);
      check("bp_valid_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    check("bp_drained", exp_q.size(), 0);

    // Bubbles are preserved: in 1,0,1 -> out 1,0,1 two cycles later.
    bub_in  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bub_out = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      in_valid = bub_in[i]; num1 = 8'($urandom); num2 = 8'($urandom); cin = 1'($urandom_range(0, 1));
      cycle();
      check("bubble_valid", out_valid, 32'(bub_out[i]));
    end
    in_valid = 1'b0;

    // Reset mid-stream: flush immediately, nothing stale afterwards.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; num1 = 8'($urandom); num2 = 8'($urandom); cin = 1'($urandom_range(0, 1));
      cycle();
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    cycle();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (out_valid) seen++;
    end
    check("midrst_no_stale", seen, 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      num1 = 8'($urandom); num2 = 8'($urandom); cin = 1'($urandom_range(0, 1));
`ifdef RCA_PIPE_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
    repeat (5) cycle();
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
